// File: rtl/esc_pkg.sv
// rtl/esc_pkg.sv - shared types, default timing constants and width helper for the ESC PWM transmitter
package esc_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARM_WAIT = 2'd1,
        RUN      = 2'd2
    } esc_state_e;

    localparam int SPD_W          = 11;
    localparam int DEF_PERIOD     = 50000;
    localparam int DEF_BASE       = 6250;
    localparam int DEF_SCALE      = 3;
    localparam int DEF_ARM_FRAMES = 50;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/esc_pwm_tx_if.sv
// rtl/esc_pwm_tx_if.sv - speed/arm bus from the flight controller and ESC pulse outputs
interface esc_pwm_tx_if;
    import esc_pkg::*;

    logic             arm;
    logic             wrt;
    logic [SPD_W-1:0] frnt_spd;
    logic [SPD_W-1:0] bck_spd;
    logic [SPD_W-1:0] lft_spd;
    logic [SPD_W-1:0] rght_spd;
    logic             frnt_pwm;
    logic             bck_pwm;
    logic             lft_pwm;
    logic             rght_pwm;
    logic             frame_start;
    logic             armed;

    modport master (
        output arm, wrt, frnt_spd, bck_spd, lft_spd, rght_spd,
        input  frnt_pwm, bck_pwm, lft_pwm, rght_pwm, frame_start, armed
    );

    modport slave (
        input  arm, wrt, frnt_spd, bck_spd, lft_spd, rght_spd,
        output frnt_pwm, bck_pwm, lft_pwm, rght_pwm, frame_start, armed
    );

endinterface

// File: rtl/esc_chan.sv
// rtl/esc_chan.sv - one ESC channel: double-buffered speed, pulse width and registered pwm
module esc_chan
    import esc_pkg::*;
#(
    parameter int PERIOD = DEF_PERIOD,
    parameter int BASE   = DEF_BASE,
    parameter int SCALE  = DEF_SCALE,
    parameter int CW     = cnt_width(DEF_PERIOD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wrt,
    input  logic [SPD_W-1:0] spd,
    input  logic             frame_end,
    input  logic             en,
    input  logic             use_base,
    input  logic [CW-1:0]    cnt,
    output logic             pwm
);

    logic [SPD_W-1:0] pending_q, pending_d;
    logic [SPD_W-1:0] active_q, active_d;
    logic             pwm_q, pwm_d;
    logic [CW-1:0]    width;
    logic [CW-1:0]    width_sel;

    always_comb begin
        pending_d = pending_q;
        active_d  = active_q;
        if (wrt) begin
            pending_d = spd;
        end
        // A write landing on the last cycle of a frame goes straight into the next frame.
        if (frame_end) begin
            active_d = wrt ? spd : pending_q;
        end
        width     = CW'(BASE) + CW'(active_q) * CW'(SCALE);
        width_sel = use_base ? CW'(BASE) : width;
        pwm_d     = en && (cnt < width_sel);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
            active_q  <= '0;
            pwm_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            active_q  <= active_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/esc_pwm_tx.sv
// rtl/esc_pwm_tx.sv - frame counter, arming FSM and four ESC pulse channels
module esc_pwm_tx
    import esc_pkg::*;
#(
    parameter int PERIOD     = DEF_PERIOD,
    parameter int BASE       = DEF_BASE,
    parameter int SCALE      = DEF_SCALE,
    parameter int ARM_FRAMES = DEF_ARM_FRAMES
) (
    input  logic         clk,
    input  logic         rst_n,
    esc_pwm_tx_if.slave  bus
);

    localparam int CW  = cnt_width(PERIOD);
    localparam int FCW = cnt_width(ARM_FRAMES);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [FCW-1:0] fc_q, fc_d;
    esc_state_e     state_q, state_d;
    logic           armed_q, armed_d;
    logic           frame_end;
    logic           en;
    logic           use_base;
    logic           frnt_pwm, bck_pwm, lft_pwm, rght_pwm;

    always_comb begin
        frame_end = (cnt_q == CW'(PERIOD - 1));
        cnt_d     = frame_end ? '0 : cnt_q + 1'b1;
        state_d   = state_q;
        fc_d      = fc_q;
        case (state_q)
            DISARMED: begin
                if (frame_end && bus.arm) begin
                    state_d = ARM_WAIT;
                    fc_d    = '0;
                end
            end
            ARM_WAIT: begin
                if (!bus.arm) begin
                    state_d = DISARMED;
                end else if (frame_end) begin
                    if (fc_q == FCW'(ARM_FRAMES - 1)) begin
                        state_d = RUN;
                    end else begin
                        fc_d = fc_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (!bus.arm) begin
                    state_d = DISARMED;
                end
            end
            default: state_d = DISARMED;
        endcase
        armed_d  = (state_d == RUN);
        // Gating with arm directly truncates a pulse on the very edge disarm is seen.
        en       = bus.arm && ((state_q == ARM_WAIT) || (state_q == RUN));
        use_base = (state_q == ARM_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            fc_q    <= '0;
            state_q <= DISARMED;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fc_q    <= fc_d;
            state_q <= state_d;
            armed_q <= armed_d;
        end
    end

    esc_chan #(.PERIOD(PERIOD), .BASE(BASE), .SCALE(SCALE), .CW(CW)) u_frnt (
        .clk(clk), .rst_n(rst_n), .wrt(bus.wrt), .spd(bus.frnt_spd), .frame_end(frame_end),
        .en(en), .use_base(use_base), .cnt(cnt_q), .pwm(frnt_pwm)
    );

    esc_chan #(.PERIOD(PERIOD), .BASE(BASE), .SCALE(SCALE), .CW(CW)) u_bck (
        .clk(clk), .rst_n(rst_n), .wrt(bus.wrt), .spd(bus.bck_spd), .frame_end(frame_end),
        .en(en), .use_base(use_base), .cnt(cnt_q), .pwm(bck_pwm)
    );

    esc_chan #(.PERIOD(PERIOD), .BASE(BASE), .SCALE(SCALE), .CW(CW)) u_lft (
        .clk(clk), .rst_n(rst_n), .wrt(bus.wrt), .spd(bus.lft_spd), .frame_end(frame_end),
        .en(en), .use_base(use_base), .cnt(cnt_q), .pwm(lft_pwm)
    );

    esc_chan #(.PERIOD(PERIOD), .BASE(BASE), .SCALE(SCALE), .CW(CW)) u_rght (
        .clk(clk), .rst_n(rst_n), .wrt(bus.wrt), .spd(bus.rght_spd), .frame_end(frame_end),
        .en(en), .use_base(use_base), .cnt(cnt_q), .pwm(rght_pwm)
    );

    assign bus.frnt_pwm    = frnt_pwm;
    assign bus.bck_pwm     = bck_pwm;
    assign bus.lft_pwm     = lft_pwm;
    assign bus.rght_pwm    = rght_pwm;
    assign bus.frame_start = (cnt_q == '0);
    assign bus.armed       = armed_q;

endmodule

// File: tb/tb_esc_pwm_tx.sv
// tb/tb_esc_pwm_tx.sv - directed frame-level checks of esc_pwm_tx with a shortened frame
module tb_esc_pwm_tx;

    localparam int P  = 2500;
    localparam int B  = 200;
    localparam int S  = 1;
    localparam int AF = 2;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;
    int   hi[4];
    int   first_hi;
    int   n_wait;
    int   armed0;
    int   armed_end;
    int   any_hi;

    esc_pwm_tx_if bus();

    esc_pwm_tx #(.PERIOD(P), .BASE(B), .SCALE(S), .ARM_FRAMES(AF)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Syncs to frame_start, then samples one whole frame; optional write/disarm at a given cnt.
    task automatic measure(input int wrt_at, input logic [10:0] f, input logic [10:0] b,
                           input logic [10:0] l, input logic [10:0] r, input int disarm_at);
        int n;
        n = 0;
        for (int k = 0; k < 4; k++) hi[k] = 0;
        first_hi = -1;
        @(negedge clk);
        bus.wrt = 1'b0;
        while (!bus.frame_start && n < P + 4) begin
            @(negedge clk);
            n++;
        end
        n_wait = n;
        if (!bus.frame_start) begin
            check_vec("frame_sync", 0, 1);
            return;
        end
        armed0 = int'(bus.armed);
        for (int i = 0; i < P; i++) begin
            if (i > 0) @(negedge clk);
            hi[0] += int'(bus.frnt_pwm);
            hi[1] += int'(bus.bck_pwm);
            hi[2] += int'(bus.lft_pwm);
            hi[3] += int'(bus.rght_pwm);
            if (bus.frnt_pwm && first_hi < 0) first_hi = i;
            bus.wrt = (i == wrt_at);
            if (i == wrt_at) begin
                bus.frnt_spd = f;
                bus.bck_spd  = b;
                bus.lft_spd  = l;
                bus.rght_spd = r;
            end
            if (i == disarm_at) bus.arm = 1'b0;
        end
        armed_end = int'(bus.armed);
    endtask

    task automatic check_frame(input string tag, input int ef, input int eb, input int el,
                               input int er, input int ea);
        check_vec({tag, "_frnt"}, hi[0], ef);
        check_vec({tag, "_bck"},  hi[1], eb);
        check_vec({tag, "_lft"},  hi[2], el);
        check_vec({tag, "_rght"}, hi[3], er);
        check_vec({tag, "_armed"}, armed0, ea);
    endtask

    initial begin
        n_vec        = 0;
        n_miss       = 0;
        rst_n        = 1'b0;
        bus.arm      = 1'b0;
        bus.wrt      = 1'b0;
        bus.frnt_spd = '0;
        bus.bck_spd  = '0;
        bus.lft_spd  = '0;
        bus.rght_spd = '0;
        repeat (5) @(negedge clk);
        check_vec("rst_pwm", int'({bus.frnt_pwm, bus.bck_pwm, bus.lft_pwm, bus.rght_pwm}), 0);
        check_vec("rst_armed", int'(bus.armed), 0);
        check_vec("rst_fstart", int'(bus.frame_start), 1);
        rst_n = 1'b1;

        for (int k = 0; k < 3; k++) begin
            measure(-1, 0, 0, 0, 0, -1);
            check_frame($sformatf("idle%0d", k), 0, 0, 0, 0, 0);
            if (k > 0) check_vec($sformatf("idle%0d_period", k), n_wait, 0);
        end

        bus.arm = 1'b1;
        for (int k = 0; k < AF; k++) begin
            measure(-1, 0, 0, 0, 0, -1);
            check_frame($sformatf("armw%0d", k), B, B, B, B, 0);
            check_vec($sformatf("armw%0d_first", k), first_hi, 1);
        end

        measure(1000, 11'd0, 11'd2047, 11'd100, 11'd1000, -1);
        check_frame("run_cur", 200, 200, 200, 200, 1);
        measure(P - 1, 11'd500, 11'd2047, 11'd100, 11'd1000, -1);
        check_frame("run_new", 200, 2247, 300, 1200, 1);
        check_vec("run_new_first", first_hi, 1);
        measure(1, 11'd10, 11'd2047, 11'd100, 11'd1000, -1);
        check_frame("bypass", 700, 2247, 300, 1200, 1);

        measure(-1, 0, 0, 0, 0, 150);
        check_frame("disarm", 150, 150, 150, 150, 1);
        check_vec("disarm_armed_end", armed_end, 0);
        measure(-1, 0, 0, 0, 0, -1);
        check_frame("disarmed", 0, 0, 0, 0, 0);

        bus.arm = 1'b1;
        for (int k = 0; k < AF; k++) begin
            measure(-1, 0, 0, 0, 0, -1);
            check_frame($sformatf("rearm%0d", k), B, B, B, B, 0);
        end
        measure(-1, 0, 0, 0, 0, -1);
        check_frame("rerun", 210, 2247, 300, 1200, 1);

        repeat (151) @(negedge clk);
        check_vec("pre_rst_pwm", int'(bus.frnt_pwm), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_vec("mid_rst_pwm", int'({bus.frnt_pwm, bus.bck_pwm, bus.lft_pwm, bus.rght_pwm}), 0);
        check_vec("mid_rst_armed", int'(bus.armed), 0);
        check_vec("mid_rst_cnt0", int'(bus.frame_start), 1);
        @(negedge clk);
        rst_n = 1'b1;
        any_hi = 0;
        repeat (300) begin
            @(negedge clk);
            any_hi |= int'({bus.frnt_pwm, bus.bck_pwm, bus.lft_pwm, bus.rght_pwm});
        end
        check_vec("post_rst_quiet", any_hi, 0);
        for (int k = 0; k < AF; k++) begin
            measure(-1, 0, 0, 0, 0, -1);
            check_frame($sformatf("post_armw%0d", k), B, B, B, B, 0);
        end
        measure(-1, 0, 0, 0, 0, -1);
        check_frame("post_run_cleared", B, B, B, B, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
